fp64_divider_seq: RTL

Iterative IEEE-754 double-precision divider (a_operand / b_operand). It is the inverse-operation companion to the team's combinational FP64 multiplier and sits beside it in the FPU datapath. It uses a radix-2 restoring divide, one quotient bit per cycle, with a valid/ready handshake on both sides. Its exception, overflow and underflow conventions match the multiplier.

---
 rtl/fp64_pkg.sv | 18 +
 rtl/fp64_div_classify.sv | 21 ++
 rtl/fp64_divider_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fp64_pkg.sv
// Shared FP64 constants and divider control-state encodings.
// Used by the sequential divider and the operand classifier.
package fp64_pkg;

   localparam int EXP_W  = 11;
   localparam int MANT_W = 52;
   localparam int BIAS   = 1023;
   localparam int Q_W    = 55;

   localparam logic [62:0] INF_MAG  = {11'h7FF, 52'd0};
   localparam logic [62:0] ZERO_MAG = 63'd0;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DIVIDE = 2'd1;
   localparam logic [1:0] NORM   = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/fp64_div_classify.sv
// FP64 operand classifier: special-value detection and hidden bits.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module fp64_div_classify
   import fp64_pkg::*;
(
   input  logic [62:0] a_mag_i,
   input  logic [62:0] b_mag_i,
   output logic        is_exc_o,
   output logic        a_zero_o,
   output logic        b_zero_o,
   output logic        hid_a_o,
   output logic        hid_b_o
);

   assign is_exc_o = (&a_mag_i[62:MANT_W]) | (&b_mag_i[62:MANT_W]);
   assign a_zero_o = (a_mag_i == ZERO_MAG);
   assign b_zero_o = (b_mag_i == ZERO_MAG);
   assign hid_a_o  = |a_mag_i[62:MANT_W];
   assign hid_b_o  = |b_mag_i[62:MANT_W];

endmodule

// File: rtl/fp64_divider_seq.sv
// Radix-2 restoring FP64 divider, one quotient bit per cycle; FP64_DIV_RNE_EN selects RNE rounding.
// Latency 57 edges (1 for special operands); result held in DONE until out_ready, in_ready only in IDLE.
module fp64_divider_seq
   import fp64_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] a_operand,
   input  logic [63:0] b_operand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result,
   output logic        Exception,
   output logic        Overflow,
   output logic        Underflow,
   output logic        DivByZero
);

   logic [1:0]        state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [53:0]       rem_q, rem_d;
   logic [Q_W-1:0]    quo_q, quo_d;
   logic [MANT_W:0]   opb_q, opb_d;
   logic [EXP_W-1:0]  exp_a_q, exp_a_d, exp_b_q, exp_b_d;
   logic              sign_q, sign_d;
   logic [63:0]       res_q, res_d;
   logic              exc_q, exc_d, ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

   logic is_exc, a_zero, b_zero, hid_a, hid_b;

   fp64_div_classify u_classify (
      .a_mag_i  (a_operand[62:0]),
      .b_mag_i  (b_operand[62:0]),
      .is_exc_o (is_exc),
      .a_zero_o (a_zero),
      .b_zero_o (b_zero),
      .hid_a_o  (hid_a),
      .hid_b_o  (hid_b)
   );

   logic              ge;
   logic [53:0]       rem_sub;
   logic [MANT_W-1:0] mant_raw, mant_fin;
   logic              rnd, adj, inc, denorm;
   logic [MANT_W:0]   mant_sum;
   logic signed [12:0] exp_s, exp_r;
`ifdef FP64_DIV_RNE_EN
   logic              sticky;
`endif

   // One restoring step; the shifted remainder always stays below 2*divisor.
   always_comb begin
      ge      = (rem_q >= {1'b0, opb_q});
      rem_sub = ge ? (rem_q - {1'b0, opb_q}) : rem_q;
   end

   always_comb begin
      adj      = ~quo_q[Q_W-1];
      mant_raw = quo_q[Q_W-1] ? quo_q[53:2] : quo_q[52:1];
      rnd      = quo_q[Q_W-1] ? quo_q[1] : quo_q[0];
      denorm   = ~quo_q[Q_W-1] & ~quo_q[Q_W-2];
      exp_s    = 13'(exp_a_q) - 13'(exp_b_q) + 13'(BIAS) - 13'(adj);
`ifdef FP64_DIV_RNE_EN
      sticky   = (quo_q[Q_W-1] & quo_q[0]) | (|rem_q);
      inc      = rnd & (sticky | mant_raw[0]);
`else
      inc      = rnd;
`endif
      mant_sum = {1'b0, mant_raw} + {{MANT_W{1'b0}}, inc};
      mant_fin = mant_sum[MANT_W] ? '0 : mant_sum[MANT_W-1:0];
      exp_r    = exp_s + {12'd0, mant_sum[MANT_W]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      opb_d   = opb_q;
      exp_a_d = exp_a_q;
      exp_b_d = exp_b_q;
      sign_d  = sign_q;
      res_d   = res_q;
      exc_d   = exc_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d  = a_operand[63] ^ b_operand[63];
               exp_a_d = a_operand[62:MANT_W];
               exp_b_d = b_operand[62:MANT_W];
               opb_d   = {hid_b, b_operand[MANT_W-1:0]};
               rem_d   = {1'b0, hid_a, a_operand[MANT_W-1:0]};
               quo_d   = '0;
               cnt_d   = '0;
               if (is_exc) begin
                  res_d   = '0;
                  exc_d   = 1'b1;
                  state_d = DONE;
               end else if (b_zero) begin
                  res_d   = {sign_d, INF_MAG};
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else if (a_zero) begin
                  res_d   = {sign_d, ZERO_MAG};
                  state_d = DONE;
               end else begin
                  state_d = DIVIDE;
               end
            end
         end
         DIVIDE: begin
            rem_d = rem_sub << 1;
            quo_d = {quo_q[Q_W-2:0], ge};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(Q_W - 1)) state_d = NORM;
         end
         NORM: begin
            state_d = DONE;
            if (denorm || exp_r <= 13'sd0) begin
               unf_d = 1'b1;
               res_d = {sign_q, ZERO_MAG};
            end else if (exp_r >= 13'sd2047) begin
               ovf_d = 1'b1;
               res_d = {sign_q, INF_MAG};
            end else begin
               res_d = {sign_q, exp_r[EXP_W-1:0], mant_fin};
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               exc_d   = 1'b0;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         opb_q   <= '0;
         exp_a_q <= '0;
         exp_b_q <= '0;
         sign_q  <= 1'b0;
         res_q   <= '0;
         exc_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else if (enable) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         opb_q   <= opb_d;
         exp_a_q <= exp_a_d;
         exp_b_q <= exp_b_d;
         sign_q  <= sign_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign Exception = exc_q;
   assign Overflow  = ovf_q;
   assign Underflow = unf_q;
   assign DivByZero = dbz_q;

endmodule
